// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package imem_pkg;

   localparam int AWIDTH_DEF = 14;
   localparam int IMEM_DW    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte-stream input and IMEM port-A / CPU-fetch side of the loader.
interface imem_load_ctrl_if
   import imem_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF
);

   // Stream handshake: a byte transfers in every cycle where in_valid && in_ready;
   // in_data must be stable while in_valid is high, in_ready never depends on in_valid.
   logic [7:0]         in_data;
   logic               in_valid;
   logic               in_ready;
   logic [AWIDTH-1:0]  fetch_addr;
   logic [AWIDTH-1:0]  imem_addra;
   logic [IMEM_DW-1:0] imem_dina;
   logic [3:0]         imem_wea;
   logic               cpu_hold;

   modport master (
      input  in_data, in_valid, fetch_addr,
      output in_ready, imem_addra, imem_dina, imem_wea, cpu_hold
   );

   modport slave (
      output in_data, in_valid, fetch_addr,
      input  in_ready, imem_addra, imem_dina, imem_wea, cpu_hold
   );

endinterface

// File: rtl/imem_load_ctrl.sv
// Streams program bytes into IMEM port A one byte lane at a time while holding the CPU;
// port A falls back to the CPU fetch address whenever no write is pending.
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int LEN_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [AWIDTH-1:0]   base_addr,
   input  logic [LEN_W-1:0]    byte_len,
   input  logic                abort,
   imem_load_ctrl_if.master    bus,
   output logic                done,
   output logic [7:0]          checksum,
   output state_t              state
);

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [7:0]        sum_q;
   logic              wr_pend;
   logic [AWIDTH-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [1:0]        wr_lane;

   logic start_acc;
   logic accept;
   logic last_byte;

   assign start_acc = start && (state_q == ST_IDLE);
   assign accept    = bus.in_valid && (state_q == ST_LOAD);
   assign last_byte = (cnt_q == len_q - LEN_W'(1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (byte_len == '0) ? ST_DONE : ST_LOAD;
         // abort wins over a simultaneous last byte; that byte is still written
         ST_LOAD: begin
            if (abort)                      state_d = ST_IDLE;
            else if (accept && last_byte)   state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         wr_pend <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_lane <= '0;
      end else begin
         state_q <= state_d;
         wr_pend <= accept;
         if (accept) begin
            wr_addr <= base_q + AWIDTH'(cnt_q >> 2);
            wr_data <= bus.in_data;
            wr_lane <= cnt_q[1:0];
            cnt_q   <= cnt_q + LEN_W'(1);
            sum_q   <= sum_q + bus.in_data;
         end
         if (start_acc) begin
            base_q <= base_addr;
            len_q  <= byte_len;
            cnt_q  <= '0;
            sum_q  <= '0;
         end
      end
   end

   always_comb begin
      bus.in_ready   = (state_q == ST_LOAD);
      bus.imem_wea   = wr_pend ? (4'b0001 << wr_lane) : 4'b0000;
      bus.imem_dina  = {4{wr_data}};
      bus.imem_addra = wr_pend ? wr_addr : bus.fetch_addr;
      bus.cpu_hold   = (state_q != ST_IDLE) || wr_pend;
   end

   assign done     = (state_q == ST_DONE);
   assign checksum = sum_q;
   assign state    = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: writes are captured on the falling edge and checked per scenario.
module tb_imem_load_ctrl;
   import imem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [13:0] base_addr;
   logic [15:0] byte_len;
   logic        abort;
   logic        done;
   logic [7:0]  checksum;
   state_t      state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [13:0] cap_addr[$];
   logic [3:0]  cap_wea[$];
   logic [31:0] cap_dat[$];

   imem_load_ctrl_if bus ();

   imem_load_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .byte_len  (byte_len),
      .abort     (abort),
      .bus       (bus),
      .done      (done),
      .checksum  (checksum),
      .state     (state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.imem_wea !== 4'b0000) begin
         cap_addr.push_back(bus.imem_addra);
         cap_wea.push_back(bus.imem_wea);
         cap_dat.push_back(bus.imem_dina);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cap;
      cap_addr.delete();
      cap_wea.delete();
      cap_dat.delete();
   endtask

   task automatic start_load(input logic [13:0] b, input logic [15:0] l);
      start     = 1'b1;
      base_addr = b;
      byte_len  = l;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; base_addr = '0; byte_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.fetch_addr = 14'h0123;
      #1;
      n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
      n_tests++; if (bus.imem_wea !== 4'h0) begin n_fail++; $display("FAIL reset_wea got=%h exp=0", bus.imem_wea); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_tests++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL reset_checksum got=%h exp=00", checksum); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got=%b exp=0", bus.cpu_hold); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.in_ready); end
      n_tests++; if (bus.imem_addra !== 14'h0123) begin n_fail++; $display("FAIL reset_addra got=%h exp=0123", bus.imem_addra); end
   endtask

   task automatic test_basic;
      clear_cap();
      start_load(14'h0010, 16'd8);
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_load got=%b exp=1", bus.in_ready); end
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(k + 1);
         tick();
      end
      bus.in_valid = 1'b0;
      abort = 1'b1;
      n_tests++; if (state !== ST_FLUSH) begin n_fail++; $display("FAIL basic_flush_state got=%0d exp=%0d", state, ST_FLUSH); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_flush got=%b exp=0", bus.in_ready); end
      n_tests++; if (bus.imem_wea !== 4'h8 || bus.imem_addra !== 14'h0011) begin
         n_fail++; $display("FAIL basic_final_write got=%h/%h exp=0011/8", bus.imem_addra, bus.imem_wea); end
      n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold got=%b exp=1", bus.cpu_hold); end
      tick();
      abort = 1'b0;
      n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", done); end
      n_tests++; if (bus.imem_wea !== 4'h0) begin n_fail++; $display("FAIL basic_wea_done got=%h exp=0", bus.imem_wea); end
      tick();
      n_tests++; if (done !== 1'b0 || state !== ST_IDLE) begin n_fail++; $display("FAIL basic_idle got=%b/%0d exp=0/0", done, state); end
      n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_release got=%b exp=0", bus.cpu_hold); end
      n_tests++; if (checksum !== 8'h24) begin n_fail++; $display("FAIL basic_checksum got=%h exp=24", checksum); end
      n_tests++; if (cap_addr.size() != 8) begin n_fail++; $display("FAIL basic_count got=%0d exp=8", cap_addr.size()); end
      for (int k = 0; k < cap_addr.size() && k < 8; k++) begin
         n_tests++;
         if (cap_addr[k] !== ((k < 4) ? 14'h0010 : 14'h0011) || cap_wea[k] !== 4'(1 << (k % 4))
             || cap_dat[k] !== {4{8'(k + 1)}}) begin
            n_fail++; $display("FAIL basic_write%0d got=%h/%h/%h", k, cap_addr[k], cap_wea[k], cap_dat[k]);
         end
      end
   endtask

   task automatic test_wrap;
      clear_cap();
      start_load(14'h3FFF, 16'd8);
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(8'hA0 + k);
         tick();
      end
      bus.in_valid = 1'b0;
      tick(); tick();
      n_tests++; if (cap_addr.size() != 8) begin n_fail++; $display("FAIL wrap_count got=%0d exp=8", cap_addr.size()); end
      for (int k = 0; k < cap_addr.size() && k < 8; k++) begin
         n_tests++;
         if (cap_addr[k] !== ((k < 4) ? 14'h3FFF : 14'h0000) || cap_wea[k] !== 4'(1 << (k % 4))) begin
            n_fail++; $display("FAIL wrap_write%0d got=%h/%h", k, cap_addr[k], cap_wea[k]);
         end
      end
      n_tests++; if (checksum !== 8'h1C) begin n_fail++; $display("FAIL wrap_checksum got=%h exp=1c", checksum); end
   endtask

   task automatic test_gaps;
      int  acc = 0;
      int  cyc = 0;
      logic v;
      logic took;
      logic seen_done = 1'b0;
      clear_cap();
      start_load(14'h0100, 16'd5);
      while (acc < 5 && cyc < 200) begin
         v = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         bus.in_valid = v;
         bus.in_data  = 8'(8'h30 + acc);
         start     = (cyc == 2);
         base_addr = 14'h0200;
         byte_len  = 16'd0;
         took = v && bus.in_ready;
         tick();
         if (took) acc++;
         cyc++;
      end
      start = 1'b0;
      bus.in_valid = 1'b0;
      n_tests++; if (acc != 5) begin n_fail++; $display("FAIL gaps_timeout got=%0d exp=5", acc); end
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         tick();
      end
      n_tests++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL gaps_done got=0 exp=1"); end
      n_tests++; if (cap_addr.size() != 5) begin n_fail++; $display("FAIL gaps_count got=%0d exp=5", cap_addr.size()); end
      for (int k = 0; k < cap_addr.size() && k < 5; k++) begin
         n_tests++;
         if (cap_addr[k] !== ((k < 4) ? 14'h0100 : 14'h0101) || cap_wea[k] !== 4'(1 << (k % 4))
             || cap_dat[k] !== {4{8'(8'h30 + k)}}) begin
            n_fail++; $display("FAIL gaps_write%0d got=%h/%h/%h", k, cap_addr[k], cap_wea[k], cap_dat[k]);
         end
      end
      n_tests++; if (checksum !== 8'hFA) begin n_fail++; $display("FAIL gaps_checksum got=%h exp=fa", checksum); end
   endtask

   task automatic test_abort;
      logic seen_done = 1'b0;
      clear_cap();
      start_load(14'h0040, 16'd10);
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(k + 1);
         tick();
      end
      bus.in_data = 8'h04;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      bus.in_valid = 1'b0;
      n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state got=%0d exp=0", state); end
      n_tests++; if (bus.imem_wea !== 4'h8 || bus.imem_addra !== 14'h0040) begin
         n_fail++; $display("FAIL abort_last_write got=%h/%h exp=0040/8", bus.imem_addra, bus.imem_wea); end
      n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL abort_hold_write got=%b exp=1", bus.cpu_hold); end
      tick();
      n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL abort_hold_drop got=%b exp=0", bus.cpu_hold); end
      for (int i = 0; i < 3; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         tick();
      end
      n_tests++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=1 exp=0"); end
      n_tests++; if (cap_addr.size() != 4) begin n_fail++; $display("FAIL abort_count got=%0d exp=4", cap_addr.size()); end
      n_tests++; if (checksum !== 8'h0A) begin n_fail++; $display("FAIL abort_checksum got=%h exp=0a", checksum); end
   endtask

   task automatic test_zero_len;
      clear_cap();
      start_load(14'h0020, 16'd0);
      n_tests++; if (done !== 1'b1 || state !== ST_DONE) begin n_fail++; $display("FAIL zero_done got=%b/%0d exp=1/3", done, state); end
      n_tests++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL zero_checksum got=%h exp=00", checksum); end
      tick();
      n_tests++; if (done !== 1'b0 || bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_idle got=%b/%b exp=0/0", done, bus.cpu_hold); end
      tick();
      n_tests++; if (cap_addr.size() != 0) begin n_fail++; $display("FAIL zero_writes got=%0d exp=0", cap_addr.size()); end
   endtask

   task automatic test_reset_mid;
      clear_cap();
      bus.fetch_addr = 14'h02AA;
      start_load(14'h0050, 16'd6);
      bus.in_valid = 1'b1; bus.in_data = 8'h55; tick();
      bus.in_data = 8'h66; tick();
      bus.in_valid = 1'b0;
      n_tests++; if (bus.imem_wea !== 4'h2) begin n_fail++; $display("FAIL rmid_pending got=%h exp=2", bus.imem_wea); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.imem_wea !== 4'h0) begin n_fail++; $display("FAIL rmid_wea got=%h exp=0", bus.imem_wea); end
      n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL rmid_hold got=%b exp=0", bus.cpu_hold); end
      n_tests++; if (checksum !== 8'h00) begin n_fail++; $display("FAIL rmid_checksum got=%h exp=00", checksum); end
      tick(); tick();
      #2 rst_n = 1'b1;
      tick();
      n_tests++; if (bus.imem_addra !== 14'h02AA) begin n_fail++; $display("FAIL rmid_addra got=%h exp=02aa", bus.imem_addra); end
      n_tests++; if (bus.cpu_hold !== 1'b0 || state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_idle got=%b/%0d exp=0/0", bus.cpu_hold, state); end
      n_tests++; if (cap_addr.size() != 1) begin n_fail++; $display("FAIL rmid_writes got=%0d exp=1", cap_addr.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_gaps();
      test_abort();
      test_zero_len();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
